// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, producing the HI/LO pair for MULT, MULTU, DIV and DIVU.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e state_q, state_d;

  // Iteration datapath: rem holds the partial product high half / partial
  // remainder, quo the multiplier / quotient, dvs the multiplicand / divisor.
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dbz_flag_q, dbz_flag_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Combinational helpers
  logic             in_signed, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH+1:0] div_trial;
  logic [PW-1:0]    prod_mag, prod_res;
  logic [WIDTH-1:0] quo_res, rem_res;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_RUN : S_IDLE;
      S_RUN:          if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:          state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dbz_flag_d = dbz_flag_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    busy_d     = (state_d == S_RUN) || (state_d == S_FIX);

    in_signed = ~op[0];
    a_neg     = in_signed & SrcA[WIDTH-1];
    b_neg     = in_signed & SrcB[WIDTH-1];
    b_zero    = (SrcB == '0);
    // The most-negative value negates to itself, which read unsigned is 2^(W-1).
    a_mag     = a_neg ? -SrcA : SrcA;
    b_mag     = b_neg ? -SrcB : SrcB;

    mul_sum   = rem_q + (quo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    div_trial = {1'b0, div_shift} - {2'b00, dvs_q};

    prod_mag  = {rem_q[WIDTH-1:0], quo_q};
    prod_res  = neg_res_q ? -prod_mag : prod_mag;
    quo_res   = neg_res_q ? -quo_q : quo_q;
    rem_res   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          is_div_d   = op[1];
          quo_d      = a_mag;
          dvs_d      = b_mag;
          rem_d      = '0;
          cnt_d      = CW'(WIDTH);
          dbz_flag_d = op[1] & b_zero;
          // A zero divisor leaves an all-ones quotient, so it must not be negated;
          // the remainder then equals |SrcA| and re-signing it restores SrcA.
          neg_res_d  = (a_neg ^ b_neg) & ~(op[1] & b_zero);
          neg_rem_d  = a_neg;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          if (!div_trial[WIDTH+1]) rem_d = div_trial[WIDTH:0];
          else                     rem_d = div_shift;
          quo_d = {quo_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
        end else begin
          rem_d = {1'b0, mul_sum[WIDTH:1]};
          quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end else begin
          hi_d = prod_res[PW-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
        done_d = 1'b1;
        dbz_d  = dbz_flag_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_flag_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dbz_flag_q <= dbz_flag_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule
